// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: data widths, opcodes and the
// fetch sequencer state encoding.
package proc_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_JMPI = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PC_RD,
        ST_PC_CAP,
        ST_MEM_REQ,
        ST_PC_UPD,
        ST_ISSUE
    } fetch_state_e;

    function automatic logic is_jmpi(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OP_JMPI;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Signals between the fetch sequencer and its PC, instruction memory and
// decode stage. The master side is the fetch sequencer.
interface instruction_fetch_if;

    logic                         pc_rd_en;
    logic                         pc_count;
    logic                         pc_dir;
    logic                         pc_wr_en;
    logic [proc_pkg::ADDR_W-1:0]  pc_load_value;
    logic [proc_pkg::ADDR_W-1:0]  pc_value;

    logic [proc_pkg::ADDR_W-1:0]  mem_addr;
    logic                         mem_rd_req;
    logic                         mem_rd_ack;
    logic [proc_pkg::INSTR_W-1:0] mem_rd_data;

    logic [proc_pkg::INSTR_W-1:0] ir_data;
    logic                         ir_valid;
    logic                         ir_ready;

    modport master (
        output pc_rd_en, pc_count, pc_dir, pc_wr_en, pc_load_value,
        output mem_addr, mem_rd_req,
        output ir_data, ir_valid,
        input  pc_value, mem_rd_ack, mem_rd_data, ir_ready
    );

    modport slave (
        input  pc_rd_en, pc_count, pc_dir, pc_wr_en, pc_load_value,
        input  mem_addr, mem_rd_req,
        input  ir_data, ir_valid,
        output pc_value, mem_rd_ack, mem_rd_data, ir_ready
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter for instruction-memory reads; expired is high once
// the count has reached MEM_TIMEOUT.
module fetch_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic count_clk,
    input  logic count_rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge count_clk or negedge count_rst_n) begin
        if (!count_rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: PC read, instruction-memory read with timeout, PC update
// (increment or immediate jump) and valid/ready issue to decode.
module instruction_fetch
    import proc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                fetch_clk,
    input  logic                fetch_rst_n,
    input  logic                fetch_en,
    input  logic                fetch_flush,
    output logic                fetch_err,
    instruction_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic         expired;
    logic         capture;
    logic         timeout_hit;

    fetch_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .count_clk   (fetch_clk),
        .count_rst_n (fetch_rst_n),
        .clr         (state_q == ST_PC_CAP),
        .en          (state_q == ST_MEM_REQ && !bus.mem_rd_ack),
        .expired     (expired)
    );

    // An ack in the expiring cycle wins; a flush beats both.
    assign capture     = (state_q == ST_MEM_REQ) && bus.mem_rd_ack && !fetch_flush;
    assign timeout_hit = (state_q == ST_MEM_REQ) && !bus.mem_rd_ack && expired && !fetch_flush;

    // NOTE: next-state is assigned a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (fetch_flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (fetch_en) state_d = ST_PC_RD;
                ST_PC_RD:   state_d = ST_PC_CAP;
                ST_PC_CAP:  state_d = ST_MEM_REQ;
                ST_MEM_REQ: begin
                    if (bus.mem_rd_ack)  state_d = ST_PC_UPD;
                    else if (expired)    state_d = ST_IDLE;
                end
                ST_PC_UPD:  state_d = ST_ISSUE;
                ST_ISSUE:   if (bus.ir_ready) state_d = fetch_en ? ST_PC_RD : ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state so strobes cannot glitch.
    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            bus.pc_rd_en      <= 1'b0;
            bus.pc_count      <= 1'b0;
            bus.pc_wr_en      <= 1'b0;
            bus.pc_load_value <= '0;
            bus.mem_addr      <= '0;
            bus.mem_rd_req    <= 1'b0;
            bus.ir_data       <= '0;
            bus.ir_valid      <= 1'b0;
            fetch_err         <= 1'b0;
        end else begin
            bus.pc_rd_en   <= (state_d == ST_PC_RD);
            bus.mem_rd_req <= (state_d == ST_MEM_REQ);
            bus.ir_valid   <= (state_d == ST_ISSUE);
            bus.pc_count   <= capture && !is_jmpi(bus.mem_rd_data);
            bus.pc_wr_en   <= capture &&  is_jmpi(bus.mem_rd_data);

            if (capture) begin
                bus.ir_data       <= bus.mem_rd_data;
                bus.pc_load_value <= bus.mem_rd_data[ADDR_W-1:0];
            end

            if (state_q == ST_PC_CAP && !fetch_flush) begin
                bus.mem_addr <= bus.pc_value;
            end

            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end
    end

    assign bus.pc_dir = 1'b0;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch sequencer between the program counter and the instruction register/decoder of the 16-bit processor. It reads the current PC and issues an instruction-memory read, waiting for a handshake with a bounded timeout. It then presents the 16-bit instruction to decode with a valid/ready handshake and advances the PC. An immediate-jump opcode is resolved locally by loading the PC from the fetched word, so the jump costs no extra decode cycle.

## Interface
- `ADDR_W`, 8, PC/instruction-memory address width.
- `INSTR_W`, 16, instruction width.
- `OP_JMPI`, 4'hF, opcode in `instr[15:12]` that triggers an immediate PC load.
- `MEM_TIMEOUT`, 15, maximum cycles to wait for `mem_rd_ack` after the request starts.
- `fetch_clk`  in  1  single clock, rising edge.
- `fetch_rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  allows a new fetch to start from IDLE.
- `fetch_flush`  in  1  abandons the in-flight fetch; takes priority over everything except reset.
- `pc_value`  in  ADDR_W  registered PC output.
- `pc_rd_en`  out  1  PC read strobe.
- `pc_count`  out  1  PC count strobe; `pc_dir` is held 0 (increment).
- `pc_dir`  out  1  constant 0.
- `pc_wr_en`  out  1  PC load strobe.
- `pc_load_value`  out  ADDR_W  PC load data.
- `mem_addr`  out  ADDR_W  instruction address, registered.
- `mem_rd_req`  out  1  read request; held until ack or timeout.
- `mem_rd_ack`  in  1  data valid this cycle.
- `mem_rd_data`  in  INSTR_W  instruction word.
- `ir_data`  out  INSTR_W  latched instruction.
- `ir_valid`  out  1  `ir_data` is valid.
- `ir_ready`  in  1  decode accepts the instruction.
- `fetch_err`  out  1  sticky memory-timeout flag; cleared only by reset.

## Operation
- States:
  - IDLE: `fetch_en`=1 -> PC_RD.
  - PC_RD: assert `pc_rd_en` for 1 cycle -> PC_CAP.
  - PC_CAP: `mem_addr <= pc_value` -> MEM_REQ.
  - MEM_REQ: assert `mem_rd_req`.
    - `mem_rd_ack` -> capture `ir_data <= mem_rd_data` -> PC_UPD.
    - Timeout -> set `fetch_err` -> IDLE.
  - PC_UPD: 1 cycle.
    - If `ir_data[15:12]==OP_JMPI`: `pc_wr_en`=1, `pc_load_value=ir_data[7:0]`.
    - Otherwise: `pc_count`=1.
    - -> ISSUE.
  - ISSUE: `ir_valid`=1.
    - `ir_ready`=1 -> PC_RD if `fetch_en`, else IDLE.
- `pc_wr_en` and `pc_count` are never asserted in the same cycle; the PC's write would otherwise be overridden by its count.
- Timeout counter:
  - Width is `$clog2(MEM_TIMEOUT+1)`; cleared on entering MEM_REQ and incremented each cycle without ack.
  - Timeout fires when the count reaches `MEM_TIMEOUT` with no ack.
  - An ack on that same cycle wins over the timeout.
- `fetch_flush`:
  - From any state, go to IDLE next edge and drop `mem_rd_req`/`ir_valid`.
  - `ir_data` is retained.
  - If flush and the PC_UPD strobe coincide, the strobe is still issued; the PC update already commits that cycle.
- An ack arriving outside MEM_REQ is ignored.
- `fetch_en` deasserted mid-fetch: the fetch completes through ISSUE, then the block goes to IDLE.

## Timing
- Reset values: all strobes 0, `mem_addr`=0, `ir_data`=0, `ir_valid`=0, `fetch_err`=0, `pc_load_value`=0, state IDLE.
- All outputs are registered or decoded purely from state; there are no combinational paths from inputs to outputs.
- Zero-wait memory (ack in the first MEM_REQ cycle):
  - `ir_valid` rises 5 cycles after leaving IDLE.
  - Back-to-back throughput with `ir_ready`=1 is one instruction per 5 cycles.
- `mem_addr` is stable for the whole of MEM_REQ.
- `ir_data` is stable while `ir_valid`=1.
- Reset mid-operation aborts immediately and asynchronously. No PC strobe may glitch high.

## Structure
- Shared package `proc_pkg`:
  - Fetch state enum.
  - Opcode constants, including `OP_JMPI`.
  - `ADDR_W` and `INSTR_W`.
- Natural sub-module `fetch_timeout_ctr`: clear/enable/expire counter, parameterised by `MEM_TIMEOUT`.
- Everything else is one FSM module.

## Test plan
- Sequential fetch: PC=0x10, memory returns 0x1234 with zero wait.
  - `mem_addr`=0x10.
  - `ir_data`=0x1234 and `ir_valid` 5 cycles after start.
  - One `pc_count` pulse; next fetch at 0x11.
- Immediate jump: memory returns 0xF0A5.
  - `pc_wr_en` pulse with `pc_load_value`=0xA5 and no `pc_count`.
  - Next `mem_addr`=0xA5.
- Wait states: ack delayed 7 cycles.
  - `mem_rd_req` held for 8 cycles; `mem_addr` is constant throughout.
  - `fetch_err`=0.
- Timeout: no ack.
  - `mem_rd_req` drops after the `MEM_TIMEOUT` count is reached; `fetch_err`=1, state IDLE.
  - `fetch_err` stays set across later fetches until `fetch_rst_n`=0.
- Backpressure and flush:
  - Hold `ir_ready`=0 for 10 cycles: `ir_valid`/`ir_data` stable and no new PC strobes.
  - Assert `fetch_flush` in MEM_REQ: `mem_rd_req`=0 next cycle, ack ignored, `ir_valid` never rises.
- Async reset while in MEM_REQ: all outputs return to their reset values without waiting for a clock edge; the fetch restarts cleanly once `fetch_en` is asserted.
